// File: rtl/morse_tx_if.sv
// morse_tx_if: valid/ready letter handshake feeding the Morse transmitter.
// MAX_ELEMS must match the transmitter it is connected to.
interface morse_tx_if #(
    parameter int MAX_ELEMS = 4
);
    localparam int LEN_W = $clog2(MAX_ELEMS + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [LEN_W-1:0]     in_len;
    logic [MAX_ELEMS-1:0] in_code;

    modport master (
        output in_valid,
        output in_len,
        output in_code,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_len,
        input  in_code,
        output in_ready
    );
endinterface

// File: rtl/morse_tx.sv
// morse_tx: serializes one Morse letter per handshake onto a single-bit line.
// dot = 1,0 ; dash = 1,1,1,0 ; each letter is followed by GAP zero bits.
// Optional feature macro: MORSE_TX_SOS_EN adds the `sos` input and an
// internal S-O-S sequencer (requires MAX_ELEMS >= 3).
module morse_tx #(
    parameter int MAX_ELEMS = 4,
    parameter int GAP       = 2
) (
    input  logic        clk,
    input  logic        rst,
    morse_tx_if.slave   bus,
`ifdef MORSE_TX_SOS_EN
    input  logic        sos,
`endif
    output logic        out,
    output logic        busy,
    output logic        done
);
    localparam int LEN_W = $clog2(MAX_ELEMS + 1);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARK,
        S_SPACE,
        S_GAP
    } state_e;

    state_e               state_q, state_d;
    logic                 out_q, out_d;
    logic                 done_q, done_d;
    logic [MAX_ELEMS-1:0] code_q, code_d;   // remaining elements, current in bit 0
    logic [LEN_W-1:0]     rem_q, rem_d;     // elements left including the current one
    logic [1:0]           mark_q, mark_d;   // mark cycles left in the current element
    logic [GAP_W-1:0]     gap_q, gap_d;     // gap cycles left

    logic                 load;
    logic                 letter_end;
    logic [MAX_ELEMS-1:0] load_code;
    logic [LEN_W-1:0]     load_len;
    logic [LEN_W-1:0]     len_clamped;

`ifdef MORSE_TX_SOS_EN
    logic       sos_active_q, sos_active_d;
    logic [1:0] sos_idx_q, sos_idx_d;       // 0 = first S, 1 = O, 2 = final S
`endif

    assign len_clamped = (bus.in_len > LEN_W'(MAX_ELEMS)) ? LEN_W'(MAX_ELEMS) : bus.in_len;
    assign busy        = (state_q != S_IDLE);
    assign out         = out_q;
    assign done        = done_q;

    // Ready only when idle and out of reset; an SOS request claims the idle slot.
    always_comb begin
        bus.in_ready = (state_q == S_IDLE) && !rst;
`ifdef MORSE_TX_SOS_EN
        if (sos) bus.in_ready = 1'b0;
`endif
    end

    // Next-state and element sequencing; a letter end either chains the next
    // SOS letter directly or returns to IDLE with a one-cycle done.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d    = state_q;
        code_d     = code_q;
        rem_d      = rem_q;
        mark_d     = mark_q;
        gap_d      = gap_q;
        done_d     = 1'b0;
        load       = 1'b0;
        letter_end = 1'b0;
        load_code  = bus.in_code;
        load_len   = len_clamped;
`ifdef MORSE_TX_SOS_EN
        sos_active_d = sos_active_q;
        sos_idx_d    = sos_idx_q;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef MORSE_TX_SOS_EN
                if (sos) begin
                    load         = 1'b1;
                    load_code    = '0;
                    load_len     = LEN_W'(3);
                    sos_active_d = 1'b1;
                    sos_idx_d    = 2'd0;
                end else
`endif
                if (bus.in_valid) begin
                    load = 1'b1;
                end
            end
            S_MARK: begin
                if (mark_q == 2'd1) begin
                    state_d = S_SPACE;
                end else begin
                    mark_d = mark_q - 2'd1;
                end
            end
            S_SPACE: begin
                rem_d  = rem_q - LEN_W'(1);
                code_d = code_q >> 1;
                if (rem_d != '0) begin
                    state_d = S_MARK;
                    mark_d  = code_d[0] ? 2'd3 : 2'd1;
                end else if (GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = GAP_W'(GAP);
                end else begin
                    letter_end = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(1)) begin
                    letter_end = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (letter_end) begin
`ifdef MORSE_TX_SOS_EN
            if (sos_active_q && (sos_idx_q != 2'd2)) begin
                load      = 1'b1;
                load_code = (sos_idx_q == 2'd0) ? '1 : '0;
                load_len  = LEN_W'(3);
                sos_idx_d = sos_idx_q + 2'd1;
            end else
`endif
            begin
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef MORSE_TX_SOS_EN
                sos_active_d = 1'b0;
`endif
            end
        end

        if (load) begin
            code_d = load_code;
            rem_d  = load_len;
            if (load_len != '0) begin
                state_d = S_MARK;
                mark_d  = load_code[0] ? 2'd3 : 2'd1;
            end else if (GAP > 0) begin
                state_d = S_GAP;
                gap_d   = GAP_W'(GAP);
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // The line is registered and high exactly while the next state is MARK.
    always_comb begin
        out_d = (state_d == S_MARK);
    end

    // Control registers with synchronous reset; a letter in flight is dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef MORSE_TX_SOS_EN
            sos_active_q <= 1'b0;
            sos_idx_q    <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            done_q  <= done_d;
`ifdef MORSE_TX_SOS_EN
            sos_active_q <= sos_active_d;
            sos_idx_q    <= sos_idx_d;
`endif
        end
    end

    // Letter datapath, always reloaded before it is read.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; IDLE never reads them and every load rewrites them.
        code_q <= code_d;
        rem_q  <= rem_d;
        mark_q <= mark_d;
        gap_q  <= gap_d;
    end
endmodule

// File: tb/tb_morse_tx.sv
// tb_morse_tx: directed checks of morse_tx (MAX_ELEMS=4, GAP=2) against
// hand-computed bit patterns; pattern bit 0 is the first bit on the line.
module tb_morse_tx;
    localparam int MAX_ELEMS = 4;
    localparam int GAP       = 2;
    localparam int LEN_W     = $clog2(MAX_ELEMS + 1);

    logic clk;
    logic rst;
    logic line_out;
    logic busy;
    logic done;
`ifdef MORSE_TX_SOS_EN
    logic sos;
`endif

    int n_checks;
    int n_errors;

    morse_tx_if #(.MAX_ELEMS(MAX_ELEMS)) bus ();

    morse_tx #(.MAX_ELEMS(MAX_ELEMS), .GAP(GAP)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
`ifdef MORSE_TX_SOS_EN
        .sos  (sos),
`endif
        .out  (line_out),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a letter, confirm ready, and take the accept edge.
    task automatic present(input string name, input logic [LEN_W-1:0] len,
                           input logic [MAX_ELEMS-1:0] code, input bit hold);
        bus.in_valid = 1'b1;
        bus.in_len   = len;
        bus.in_code  = code;
        check({name, "_ready"}, bus.in_ready, 1'b1);
        step();
        if (!hold) bus.in_valid = 1'b0;
    endtask

    // Expect n line bits then the done cycle.
    task automatic expect_letter(input string name, input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_out%0d", name, i), line_out, pat[i]);
            check($sformatf("%s_busy%0d", name, i), busy, 1'b1);
            check($sformatf("%s_rdy%0d", name, i), bus.in_ready, 1'b0);
            check($sformatf("%s_done%0d", name, i), done, 1'b0);
            step();
        end
        check({name, "_done"}, done, 1'b1);
        check({name, "_idle_busy"}, busy, 1'b0);
        check({name, "_idle_out"}, line_out, 1'b0);
        check({name, "_idle_rdy"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pat_s;
        logic [31:0] pat_o;
        logic [31:0] pat_len7;
        logic [31:0] pat_sos;

        n_checks = 0;
        n_errors = 0;
        pat_s    = 32'b00010101;             // 1,0,1,0,1,0,0,0
        pat_o    = 32'b00011101110111;       // 1110 1110 1110 00
        pat_len7 = 32'b00010111010111;       // dash dot dash dot, 00
        pat_sos  = {2'b00, 8'b00010101, 14'b00011101110111, 8'b00010101};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_len   = '0;
        bus.in_code  = '0;
`ifdef MORSE_TX_SOS_EN
        sos          = 1'b0;
`endif
        step();
        step();
        check("rst_out", line_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", bus.in_ready, 1'b1);

        // Letter S.
        present("S", 3'd3, 4'b0000, 1'b0);
        expect_letter("S", pat_s, 8);

        // Letter O.
        present("O", 3'd3, 4'b0111, 1'b0);
        expect_letter("O", pat_o, 14);

        // Back-to-back S then O with valid held; O's data is visible while
        // busy and must only be taken on S's done cycle.
        present("BB_S", 3'd3, 4'b0000, 1'b1);
        bus.in_code = 4'b0111;
        expect_letter("BB_S", pat_s, 8);
        step();
        bus.in_valid = 1'b0;
        expect_letter("BB_O", pat_o, 14);

        // Empty letter: gap only.
        present("L0", 3'd0, 4'b1111, 1'b0);
        expect_letter("L0", 32'b0, 2);

        // Length beyond MAX_ELEMS clamps to 4 elements.
        present("L7", 3'd7, 4'b0101, 1'b0);
        expect_letter("L7", pat_len7, 14);

        // Reset in the 3rd cycle of a dash.
        present("RD", 3'd1, 4'b0001, 1'b0);
        check("RD_out0", line_out, 1'b1);
        step();
        check("RD_out1", line_out, 1'b1);
        step();
        check("RD_out2", line_out, 1'b1);
        rst = 1'b1;
        #1;
        check("RD_rst_ready", bus.in_ready, 1'b0);
        step();
        check("RD_rst_out", line_out, 1'b0);
        check("RD_rst_busy", busy, 1'b0);
        check("RD_rst_done", done, 1'b0);
        rst = 1'b0;
        #1;
        check("RD_rel_ready", bus.in_ready, 1'b1);
        present("RD_S", 3'd3, 4'b0000, 1'b0);
        expect_letter("RD_S", pat_s, 8);

`ifdef MORSE_TX_SOS_EN
        // SOS request beats a simultaneous letter; one done after 30 bits.
        sos          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_len   = 3'd1;
        bus.in_code  = 4'b0001;
        #1;
        check("SOS_ready", bus.in_ready, 1'b0);
        step();
        sos          = 1'b0;
        bus.in_valid = 1'b0;
        expect_letter("SOS", pat_sos, 30);
        step();
        check("SOS_after_busy", busy, 1'b0);
        check("SOS_after_out", line_out, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/morse_tx.md
# morse_tx

Morse element transmitter for the SOS signalling path: accepts one letter (up to `MAX_ELEMS` dot/dash elements) per valid/ready handshake and serializes it onto a single-bit line, one bit per clock. Encoding matches the detector side: dot = `1,0`; dash = `1,1,1,0`; every letter is followed by `GAP` extra `0` bits. It drives the line consumed by the dot/dash/SOS detectors and serves as their stimulus source in loopback.

## Interface
- `MAX_ELEMS`, 4, maximum elements per letter (≥1).
- `GAP`, 2, extra `0` cycles appended after each letter (≥0).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  letter available.
- `in_ready`  out  1  block can accept a letter this cycle.
- `in_len`  in  $clog2(MAX_ELEMS+1)  number of elements.
- `in_code`  in  MAX_ELEMS  element types; bit 0 sent first; 1 = dash, 0 = dot.
- `out`  out  1  serial Morse line, registered.
- `busy`  out  1  letter in progress (not IDLE).
- `done`  out  1  one-cycle pulse: letter (or SOS burst) fully sent.
- `sos`  in  1  only with `MORSE_TX_SOS_EN`: send built-in S-O-S.

## Operation
- States: IDLE, MARK (emitting 1s), SPACE (element-trailing 0), GAP (inter-letter 0s).
- IDLE: `out`=0, `busy`=0, `in_ready`=1 (gated low while `rst`=1 and, with macro, while `sos`=1).
- Accept on rising edge where `in_valid & in_ready`: latch `in_code`/`in_len`, element index = 0, go to MARK with mark count 1 (dot) or 3 (dash).
- MARK: `out`=1 for mark count cycles, then SPACE. SPACE: `out`=0 one cycle; if more elements, next element's MARK, else GAP (or IDLE if `GAP`=0).
- GAP: `out`=0 for `GAP` cycles, then IDLE.
- `done`=1 in the first IDLE cycle after a letter; a new letter may be accepted in that same cycle.
- `in_len`=0: no elements; letter is `GAP` zeros only; if `GAP`=0 as well, `done` pulses the cycle after acceptance.
- `in_len` > `MAX_ELEMS`: clamped to `MAX_ELEMS`. `in_code` bits at index ≥ len ignored.
- `in_valid` while not ready: ignored, no latching; upstream holds data.
- `rst` at any time, including mid-letter: next edge state=IDLE, `out`=0, `done`=0, `busy`=0, latched letter discarded.
- Reset values: `out`=0, `busy`=0, `done`=0; `in_ready`=0 while `rst` asserted, 1 the first cycle after.

## Timing
- Accept at edge N → first element bit on `out` in cycle N+1 (one-cycle latency).
- Letter duration = Σ(2 per dot, 4 per dash) + `GAP` cycles; `done` in the following cycle.
- Back-to-back letters with `in_valid` held: no idle bit between the last GAP bit and the next letter's first bit beyond the `done`/accept cycle (one cycle `out`=0).
- `busy` deasserts in the same cycle `done` asserts.

## Configuration
- `MORSE_TX_SOS_EN` defined: `sos` port present. `sos`=1 sampled in IDLE takes priority over `in_valid` (not accepted that cycle); block sends S(000,len 3), O(111,len 3), S(000,len 3) internally, each followed by `GAP` zeros, with no IDLE cycles between letters; single `done` after the final S. `sos` ignored when not IDLE.
- Undefined: no `sos` port, no SOS sequencer; letters only via handshake.

## Test plan
- S (code 000, len 3, GAP=2): `out` = 1,0,1,0,1,0,0,0 from N+1, `done` at N+9, `in_ready` 0 during N+1..N+8.
- O (code 111, len 3, GAP=2): `out` = 1110 1110 1110 00 (14 cycles), `done` at N+15.
- Back-to-back S then O with `in_valid` held: second accepted on `done` cycle; `out` total 8+1+14 bits, exactly one `done` per letter.
- `in_len`=0, GAP=2: `out`=0,0, `done` at N+3; `in_len`=7 with MAX_ELEMS=4 sends 4 elements.
- `rst` asserted at 3rd cycle of a dash: next cycle `out`=0, `busy`=0; after release `in_ready`=1 and new letter sends cleanly.
- With `MORSE_TX_SOS_EN`, `sos` pulse plus simultaneous `in_valid`: 30-cycle S-O-S pattern, `in_valid` not accepted, single `done` at cycle 31.
